// File: rtl/flux_read_scheduler_pkg.sv
// flux_sched_pkg: shared state encoding and tag helpers for flux_read_scheduler.
// Holds the FSM state enum, the default tag width derivation and tag_of(),
// which extracts the flow tag from the top TAG_WIDTH bits of a FIFO word.
package flux_sched_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, CAPT = 2'd2} state_t;

    localparam int FLUX_DEF  = 2;
    localparam int WIDTH_DEF = 8;
    localparam int TAG_WIDTH = $clog2(FLUX_DEF);

    // Word is passed zero-extended so one helper serves any WIDTH up to 64.
    function automatic int unsigned tag_of(input logic [63:0] word, input int width, input int tw);
        return int'(word >> (width - tw)) & ((1 << tw) - 1);
    endfunction

endpackage

// File: rtl/flux_read_scheduler_if.sv
// flux_read_scheduler_if: FIFO-read and consumer-side signals of flux_read_scheduler.
// Ports (master = scheduler side):
//   en           in   start new reads when high
//   fifo_empty   in   per-flow FIFO empty
//   fifo_dataout in   FIFO word, valid the cycle after fifo_rd
//   fifo_rd      out  one-hot/zero read strobe
//   out_data     out  per-flow captured words, flow i at [i*WIDTH +: WIDTH]
//   out_valid    out  per-flow slot full
//   out_ready    in   per-flow consumer accept
//   tag_err      out  sticky tag mismatch flag
//   busy         out  FSM not idle
interface flux_read_scheduler_if #(parameter int WIDTH = 8, parameter int FLUX = 2);

    logic                  en;
    logic [FLUX-1:0]       fifo_empty;
    logic [WIDTH-1:0]      fifo_dataout;
    logic [FLUX-1:0]       fifo_rd;
    logic [FLUX*WIDTH-1:0] out_data;
    logic [FLUX-1:0]       out_valid;
    logic [FLUX-1:0]       out_ready;
    logic                  tag_err;
    logic                  busy;

    modport master (
        input  en, fifo_empty, fifo_dataout, out_ready,
        output fifo_rd, out_data, out_valid, tag_err, busy
    );

    modport slave (
        output en, fifo_empty, fifo_dataout, out_ready,
        input  fifo_rd, out_data, out_valid, tag_err, busy
    );

endinterface

// File: rtl/flux_read_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports: req (per-flow request), last (previous grant) -> gnt_idx (winner), gnt_valid (any request).
// The search starts at last+1 and wraps; the first requesting flow wins.
module rr_pick #(
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = $clog2(FLUX)
) (
    input  logic [FLUX-1:0]      req,
    input  logic [TAG_WIDTH-1:0] last,
    output logic [TAG_WIDTH-1:0] gnt_idx,
    output logic                 gnt_valid
);

    logic [TAG_WIDTH-1:0] j;

    // Scanning from the farthest offset down lets the nearest request overwrite.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        j         = '0;
        for (int k = FLUX; k >= 1; k--) begin
            j = TAG_WIDTH'((int'(last) + k) % FLUX);
            if (req[j]) begin
                gnt_idx   = j;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/flux_read_scheduler.sv
// flux_read_scheduler: round-robin read scheduler for the shared-memory multi-flow FIFO.
// Ports: ck (clock), rst (sync active-low reset), s (flux_read_scheduler_if.master:
//   en, fifo_empty, fifo_dataout, fifo_rd, out_data, out_valid, out_ready, tag_err, busy).
// One read is in flight at a time: IDLE -> READ (strobe) -> CAPT (capture), with
// CAPT able to launch the next READ directly for one word every two cycles.
module flux_read_scheduler
    import flux_sched_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = $clog2(FLUX)
) (
    input logic                  ck,
    input logic                  rst,
    flux_read_scheduler_if.master s
);

    state_t               state, state_nxt;
    logic [TAG_WIDTH-1:0] grant;
    logic [TAG_WIDTH-1:0] pick;
    logic [TAG_WIDTH-1:0] tag;
    logic [FLUX-1:0]      elig;
    logic                 pick_valid;
    logic                 start;

    // grant is both the flow being read/captured and the round-robin pointer.
    always_comb begin
        elig = '0;
        for (int i = 0; i < FLUX; i++)
            elig[i] = !s.fifo_empty[i] && (!s.out_valid[i] || s.out_ready[i]) &&
                      !(state == CAPT && grant == TAG_WIDTH'(i));
    end

    rr_pick #(.FLUX(FLUX), .TAG_WIDTH(TAG_WIDTH)) u_pick (
        .req       (elig),
        .last      (grant),
        .gnt_idx   (pick),
        .gnt_valid (pick_valid)
    );

    always_ff @(posedge ck)
        state <= !rst ? IDLE : state_nxt;

    always_comb
        state_nxt = (state == READ) ? CAPT : (start ? READ : IDLE);

    always_comb begin
        start  = s.en && pick_valid && state != READ;
        s.busy = state != IDLE;
        tag    = TAG_WIDTH'(tag_of(64'(s.fifo_dataout), WIDTH, TAG_WIDTH));
    end

    // A capture into a slot wins over the consumer draining it in the same cycle.
    always_ff @(posedge ck) begin
        if (!rst) begin
            s.fifo_rd   <= '0;
            s.out_valid <= '0;
            s.out_data  <= '0;
            s.tag_err   <= 1'b0;
            grant       <= TAG_WIDTH'(FLUX - 1);
        end else begin
            s.fifo_rd <= start ? FLUX'(1) << pick : '0;
            if (start)
                grant <= pick;
            s.tag_err <= s.tag_err | (state == CAPT && tag != grant);
            for (int i = 0; i < FLUX; i++) begin
                if (state == CAPT && grant == TAG_WIDTH'(i)) begin
                    s.out_valid[i]                <= 1'b1;
                    s.out_data[i*WIDTH +: WIDTH] <= s.fifo_dataout;
                end else if (s.out_ready[i]) begin
                    s.out_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_flux_read_scheduler.sv
// tb_flux_read_scheduler: directed vector table plus randomized run against a reference model.
module tb_flux_read_scheduler;

    localparam int WIDTH = 8;
    localparam int FLUX  = 2;

    logic ck  = 1'b0;
    logic rst = 1'b0;
    always #5 ck = ~ck;

    flux_read_scheduler_if #(.WIDTH(WIDTH), .FLUX(FLUX)) bus ();

    flux_read_scheduler #(.WIDTH(WIDTH), .FLUX(FLUX)) dut (
        .ck  (ck),
        .rst (rst),
        .s   (bus.master)
    );

    typedef struct {
        logic       rst, en;
        logic [1:0] empty;
        logic [7:0] din;
        logic [1:0] rdy;
        logic [1:0] rd, vld;
        logic [7:0] d0, d1;
        logic       err, busy;
    } row_t;

    row_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: outputs expected in the current cycle.
    logic [1:0] m_rd, m_prev, n_rd;
    logic [1:0] m_vld, n_vld;
    logic [7:0] m_d[FLUX];
    logic [7:0] n_d[FLUX];
    logic       m_err, n_err;
    int         m_last;
    logic [7:0] q[FLUX][$];
    logic [7:0] word;
    logic [1:0] prev_drd;

    function automatic row_t mk(logic r, logic e, logic [1:0] em, logic [7:0] di, logic [1:0] rd_y,
                                logic [1:0] rd, logic [1:0] v, logic [7:0] d0, logic [7:0] d1,
                                logic er, logic b);
        row_t t;
        t = '{r, e, em, di, rd_y, rd, v, d0, d1, er, b};
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(logic [1:0] oh);
        return oh[1] ? 1 : 0;
    endfunction

    initial begin
        // Reset held for 3 cycles with random inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge ck);
            rst                  = 1'b0;
            bus.en               = 1'($urandom);
            bus.fifo_empty       = 2'($urandom);
            bus.fifo_dataout     = 8'($urandom);
            bus.out_ready        = 2'($urandom);
        end

        tbl.push_back(mk(1, 1, 2'b10, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 2'b10, 8'h00, 2'b00, 2'b01, 2'b00, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(1, 1, 2'b11, 8'h2A, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(1, 1, 2'b11, 8'h00, 2'b00, 2'b00, 2'b01, 8'h2A, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 2'b01, 8'h00, 2'b00, 2'b00, 2'b01, 8'h2A, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 2'b01, 8'h00, 2'b00, 2'b10, 2'b01, 8'h2A, 8'h00, 0, 1));
        tbl.push_back(mk(1, 1, 2'b11, 8'h05, 2'b00, 2'b00, 2'b01, 8'h2A, 8'h00, 0, 1));
        tbl.push_back(mk(1, 1, 2'b11, 8'h00, 2'b01, 2'b00, 2'b11, 8'h2A, 8'h05, 1, 0));
        tbl.push_back(mk(1, 1, 2'b11, 8'h00, 2'b11, 2'b00, 2'b10, 8'h2A, 8'h05, 1, 0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1, 1, 2'b11, 8'h00, 2'b00, 2'b00, 2'b00, 8'h2A, 8'h05, 1, 0));
        tbl.push_back(mk(1, 1, 2'b10, 8'h00, 2'b00, 2'b00, 2'b00, 8'h2A, 8'h05, 1, 0));
        tbl.push_back(mk(0, 1, 2'b10, 8'h00, 2'b00, 2'b01, 2'b00, 8'h2A, 8'h05, 1, 1));
        tbl.push_back(mk(1, 1, 2'b11, 8'h77, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 2'b00, 8'h00, 2'b00, 2'b01, 2'b00, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(1, 0, 2'b00, 8'h3C, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 0, 2'b00, 8'h00, 2'b00, 2'b00, 2'b01, 8'h3C, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 2'b00, 8'h00, 2'b00, 2'b00, 2'b01, 8'h3C, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 2'b00, 8'h00, 2'b00, 2'b10, 2'b01, 8'h3C, 8'h00, 0, 1));

        foreach (tbl[k]) begin
            @(negedge ck);
            rst              = tbl[k].rst;
            bus.en           = tbl[k].en;
            bus.fifo_empty   = tbl[k].empty;
            bus.fifo_dataout = tbl[k].din;
            bus.out_ready    = tbl[k].rdy;
            #1;
            chk($sformatf("vec%0d fifo_rd", k), 32'(bus.fifo_rd), 32'(tbl[k].rd));
            chk($sformatf("vec%0d out_valid", k), 32'(bus.out_valid), 32'(tbl[k].vld));
            chk($sformatf("vec%0d out_data0", k), 32'(bus.out_data[7:0]), 32'(tbl[k].d0));
            chk($sformatf("vec%0d out_data1", k), 32'(bus.out_data[15:8]), 32'(tbl[k].d1));
            chk($sformatf("vec%0d tag_err", k), 32'(bus.tag_err), 32'(tbl[k].err));
            chk($sformatf("vec%0d busy", k), 32'(bus.busy), 32'(tbl[k].busy));
        end

        // Randomized run: FIFO modelled as per-flow queues, DUT checked against
        // round-robin/slot rules evaluated from the model's own history.
        m_rd = '0; m_prev = '0; m_vld = '0; m_err = 1'b0; m_last = FLUX - 1;
        foreach (m_d[i]) m_d[i] = '0;
        prev_drd = '0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge ck);
            if (t > 0) begin
                chk("rnd fifo_rd", 32'(bus.fifo_rd), 32'(m_rd));
                chk("rnd out_valid", 32'(bus.out_valid), 32'(m_vld));
                chk("rnd out_data0", 32'(bus.out_data[7:0]), 32'(m_d[0]));
                chk("rnd out_data1", 32'(bus.out_data[15:8]), 32'(m_d[1]));
                chk("rnd tag_err", 32'(bus.tag_err), 32'(m_err));
                chk("rnd busy", 32'(bus.busy), 32'(m_rd != 0 || m_prev != 0));
                if (prev_drd != 0)
                    chk("rnd rd back-to-back", 32'(bus.fifo_rd), 32'd0);
            end
            prev_drd = bus.fifo_rd;
            rst = !(t < 2 || $urandom_range(0, 399) == 0);
            if (m_prev != 0)
                word = q[idx_of(m_prev)].pop_front();
            else
                word = 8'($urandom);
            for (int i = 0; i < FLUX; i++)
                if (q[i].size() < 4 && $urandom_range(0, 2) == 0)
                    q[i].push_back({($urandom_range(0, 59) == 0) ? 1'(~i) : 1'(i), 7'($urandom)});
            bus.fifo_dataout = word;
            for (int i = 0; i < FLUX; i++)
                bus.fifo_empty[i] = q[i].size() == 0;
            bus.en        = (t < 800) ? 1'b1 : ($urandom_range(0, 4) != 0);
            bus.out_ready = (t < 800) ? 2'b11 : 2'($urandom_range(0, 3) == 0 ? 0 : $urandom);

            if (!rst) begin
                n_rd = '0; n_vld = '0; n_err = 1'b0; m_last = FLUX - 1;
                foreach (n_d[i]) n_d[i] = '0;
                foreach (q[i]) q[i].delete();
                m_prev = '0;
            end else begin
                logic [1:0] elig;
                int         cf, g;
                logic       cap;
                cap = m_prev != 0;
                cf  = idx_of(m_prev);
                for (int i = 0; i < FLUX; i++)
                    elig[i] = q[i].size() > 0 && (!m_vld[i] || bus.out_ready[i]) && !(cap && cf == i);
                n_rd = '0;
                g    = -1;
                if (m_rd == 0 && bus.en && elig != 0)
                    for (int k = 1; k <= FLUX; k++)
                        if (g < 0 && elig[(m_last + k) % FLUX])
                            g = (m_last + k) % FLUX;
                if (g >= 0) begin
                    n_rd[g] = 1'b1;
                    m_last  = g;
                end
                for (int i = 0; i < FLUX; i++) begin
                    n_vld[i] = (cap && cf == i) ? 1'b1 : m_vld[i] && !bus.out_ready[i];
                    n_d[i]   = (cap && cf == i) ? word : m_d[i];
                end
                n_err  = m_err | (cap && int'(word[7]) != cf);
                m_prev = m_rd;
            end
            m_rd  = n_rd;
            m_vld = n_vld;
            m_err = n_err;
            foreach (m_d[i]) m_d[i] = n_d[i];
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flux_read_scheduler.md
# flux_read_scheduler

Read-side scheduler for the shared-memory multi-flow FIFO. It decides which flow's head word is read each cycle, using round-robin among flows that are non-empty and whose consumer slot is free. It drives the FIFO's one-hot `rd` vector, captures the returned word into a per-flow output register and presents it to FLUX independent consumers with a valid/ready handshake. It sits between the FIFO's `rd`/`empty`/`dataout` ports and the per-flow downstream actors.

## Interface
- WIDTH, 8: word width including tag MSBs; equals the FIFO's WIDTH.
- FLUX, 2: number of flows and consumers; FLUX ≥ 2.
- TAG_WIDTH, $clog2(FLUX): tag field width, located at word bits [WIDTH-1 : WIDTH-TAG_WIDTH].

Ports:
- ck  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- en  in  1  when 0, no new read is started; a read already in flight still completes.
- fifo_empty  in  FLUX  per-flow empty from the FIFO.
- fifo_dataout  in  WIDTH  FIFO read data, valid in the cycle after `fifo_rd`.
- fifo_rd  out  FLUX  registered, one-hot or zero; read strobe to the FIFO.
- out_data  out  FLUX*WIDTH  per-flow captured word; flow i occupies slice [i*WIDTH +: WIDTH].
- out_valid  out  FLUX  per-flow slot holds a word.
- out_ready  in  FLUX  per-flow consumer accept.
- tag_err  out  1  sticky flag: a captured word's tag did not match the granted flow.
- busy  out  1  FSM not in IDLE.

## Operation
- FSM has three states:
  - IDLE: wait for an eligible flow.
  - READ: `fifo_rd[g]` is high for this one cycle.
  - CAPT: at the end of this cycle, `fifo_dataout` is written into slot g.
- Eligibility of flow i: `!fifo_empty[i] && (!out_valid[i] || out_ready[i])`.
  - In CAPT, flow g is additionally excluded.
- Selection uses round-robin.
  - Search starts at `last_grant+1` (mod FLUX) and wraps; the first eligible flow wins.
  - `last_grant` updates when a flow enters READ.
- Transitions:
  - IDLE→READ when en=1 and at least one flow is eligible; grant g is registered and `fifo_rd` is set to one-hot g.
  - READ→CAPT unconditionally; `fifo_rd` returns to 0.
  - CAPT→READ if en=1 and a flow is eligible (new grant); otherwise CAPT→IDLE.
- Capture in CAPT:
  - `out_data[g] <= fifo_dataout`, `out_valid[g] <= 1`.
  - If tag ≠ g, set `tag_err`. It clears only on reset.
- Consumer handshake:
  - Transfer on flow i when `out_valid[i] && out_ready[i]`.
  - `out_valid[i]` drops the next cycle unless a capture into slot i happens in the same cycle, in which case valid stays 1 and the data is replaced.
- Only one FIFO read is ever in flight. This guarantees `fifo_empty` is sampled only after the previous read has updated the FIFO's occupancy.
- Reset values (rst=0 at a rising edge): state=IDLE, fifo_rd=0, out_valid=0, out_data=0, tag_err=0, last_grant=FLUX-1 (so flow 0 wins first), busy=0.
- Reset mid-operation: a pending capture is dropped. Re-aligning the FIFO is the system's job; the FIFO is reset from the same source.

## Timing
- Latency: eligible in cycle N (IDLE) → `fifo_rd` high in N+1 → capture at the end of N+2 → `out_valid` high in N+3.
- Peak throughput is one word per 2 cycles, alternating READ/CAPT.
- All outputs are registered except `busy`, which is decoded from state.
- Simultaneous events in CAPT:
  - Flow g's slot is excluded from the next grant even if its consumer accepts that cycle.
  - A different flow may be granted in the same cycle.
- `en` falling during READ: CAPT still occurs, then the FSM goes to IDLE.
- `fifo_empty[g]` rising during READ is ignored; the read was already committed.

## Structure
- Package `flux_sched_pkg`:
  - state enum: IDLE=2'd0, READ=2'd1, CAPT=2'd2;
  - `tag_of(word)` extraction function;
  - TAG_WIDTH derivation.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: req[FLUX], last[TAG_WIDTH].
  - Outputs: gnt_idx, gnt_valid.
- The top level holds the FSM, the slot registers and the error flag.

## Test plan
- Reset: hold rst=0 for 3 cycles with inputs random → every output 0, state IDLE; first grant after release goes to flow 0 when flows 0 and 1 are both eligible.
- Single flow: fifo_empty=2'b10, word 8'h2A (tag 0) → fifo_rd=2'b01 in N+1, out_data[0]=8'h2A and out_valid[0]=1 in N+3, tag_err=0.
- Fairness: both flows always non-empty, out_ready=2'b11 → grants alternate 0,1,0,1; fifo_rd is never high on two consecutive cycles.
- Backpressure: out_ready[0]=0 with slot 0 full, flow 0 non-empty → no rd[0] issued; flow 1 keeps being served every 2 cycles; raising out_ready[0] → rd[0] within 2 cycles.
- Tag error: grant flow 1, return 8'h05 (tag 0) → tag_err=1 from N+3 and held through 10 further cycles; cleared only by reset.
- Mid-op reset and en: rst=0 in the READ cycle → fifo_rd=0 and out_valid=0 the next cycle; en=0 during CAPT → capture completes, FSM goes to IDLE, no further rd while en=0.
